pipe_insn_ctrl: RTL and testbench
=================================

Name: pipe_insn_ctrl

Overview:
- Owns the PC and the instruction pipeline registers (F/D, D/X, X/M, M/W) of the 5-stage core.
- Consumes the load-use stall from the hazard unit, the taken-branch flush from execute and the multdiv busy signal.
- Produces the per-stage instruction words and PCs that feed hazard detection, the bypass selectors, the ALU and writeback.
- Inserts nops (all-zero insn, writes $r0) on stall and flush, and keeps saturating stall/flush performance counters.

Parameters:
- ADDR_W, 12, PC and instruction-memory address width.
- INSN_W, 32, instruction width.
- NOP, 32'h0000_0000, bubble word; rd=$r0, so bypass logic ignores it.
- CNT_W, 16, performance counter width.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_insn  in  INSN_W  instruction read at pc (combinational ROM output).
- ld_stall  in  1  load-use stall from hazard unit, relative to fd_insn/dx_insn.
- md_busy  in  1  multdiv occupying execute; freezes F, D, X.
- br_taken  in  1  taken branch/jump resolved in execute.
- br_target  in  ADDR_W  redirect PC, valid with br_taken.
- pc  out  ADDR_W  fetch PC to imem.
- fd_insn, dx_insn, xm_insn, mw_insn  out  INSN_W  stage instruction words.
- fd_pc, dx_pc  out  ADDR_W  PC+1 of the instruction in that stage.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Reset, synchronous: pc=0, all *_insn=NOP, fd_pc=dx_pc=0, counters=0. Reset mid-operation discards everything in flight and ignores all inputs in that cycle. Fetch restarts at 0 on the next cycle.
- Effective flush: flush = br_taken & ~md_busy. br_taken is ignored while md_busy=1, because a branch cannot occupy X while multdiv does.
- Priority per edge: reset > flush > md_busy > ld_stall > advance.
- pc:
  - flush: br_target.
  - md_busy or ld_stall: hold.
  - otherwise: pc+1, modulo 2^ADDR_W, so 4095 wraps to 0.
- F/D:
  - flush: NOP, fd_pc=0.
  - md_busy or ld_stall: hold.
  - otherwise: imem_insn, fd_pc=pc+1.
- D/X:
  - flush: NOP.
  - md_busy: hold.
  - ld_stall: NOP bubble, dx_pc=0.
  - otherwise: fd_insn, fd_pc.
- X/M:
  - md_busy: NOP. Multdiv results write back via their own path.
  - otherwise: dx_insn. This includes the branch itself on flush; the branch is never squashed.
- M/W: always xm_insn. Never stalls.
- Latency: an insn fetched at edge N is in F/D after N, D/X after N+1, X/M after N+2, M/W after N+3, absent stalls.
- A flush squashes exactly the 2 younger insns (F/D, D/X) and costs 2 cycles.
- ld_stall inserts exactly 1 bubble per asserted cycle. ld_stall held for k cycles inserts k bubbles.
- stall_cnt increments by 1 on each edge where (ld_stall | md_busy) & ~flush & ~reset. It saturates at 2^CNT_W-1.
- flush_cnt increments on each effective flush and also saturates. Neither counter wraps.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP constant.
  - Field positions: opcode [31:27], rd [26:22], rs [21:17], rt [16:12].
  - Reserved regs $r30 (status) and $r31 (link).
- One natural sub-module: pipe_reg (parameter W). Synchronous reset, enable (hold when low), and clear-to-value (bubble insert).
- Each stage is one pipe_reg pair (insn + pc).
- The counters are one small saturating counter sub-block, instantiated twice.

Test Plan:
- Reset then 6 free-running cycles, imem_insn=32'h0800_0001+pc:
  - pc steps 0..6.
  - mw_insn equals the word fetched at pc=2 on cycle 6.
  - counters stay 0.
- ld_stall=1 for one cycle with fd_insn=X:
  - pc and fd_insn hold.
  - dx_insn=NOP next cycle, then X on the following cycle.
  - stall_cnt=1.
- br_taken=1, br_target=12'h100, with A in F/D and B in D/X:
  - next cycle pc=0x100, fd_insn=NOP, dx_insn=NOP.
  - xm_insn=branch.
  - flush_cnt=1.
- md_busy=1 for 3 cycles:
  - pc, fd_insn, dx_insn unchanged.
  - xm_insn=NOP for 3 cycles.
  - stall_cnt=3.
  - br_taken asserted meanwhile is ignored (flush_cnt unchanged).
- pc=12'hFFF, free-running: next pc=0.
- Drive stall_cnt to 16'hFFFF, hold ld_stall: it stays at FFFF.
- Assert reset during a flush: all outputs go to reset values next edge and pc=0, not br_target.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction pipeline control slice:
// bubble word, instruction field positions and reserved registers.
package pipe_pkg;

    localparam int INSN_WIDTH = 32;

    localparam logic [INSN_WIDTH-1:0] NOP_INSN = 32'h0000_0000;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 17;
    localparam int RT_MSB  = 16;
    localparam int RT_LSB  = 12;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_LINK   = 5'd31;

    typedef enum logic [1:0] {
        STAGE_ADVANCE = 2'd0,
        STAGE_HOLD    = 2'd1,
        STAGE_BUBBLE  = 2'd2
    } stage_op_e;

    function automatic logic [4:0] insn_rd(input logic [INSN_WIDTH-1:0] insn);
        return insn[RD_MSB:RD_LSB];
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// One pipeline register: synchronous reset, hold when en_i is low, and
// clear-to-CLR_VAL (bubble insert) which takes priority over the enable.
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= CLR_VAL;
        end else if (clr_i) begin
            q_q <= CLR_VAL;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter: counts inc_i pulses and sticks at all-ones.
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every variable driven here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_insn_ctrl.sv
// PC and F/D, D/X, X/M, M/W instruction registers of the 5-stage core,
// with nop insertion on stall/flush and saturating stall/flush counters.
module pipe_insn_ctrl
    import pipe_pkg::*;
#(
    parameter int                ADDR_W = 12,
    parameter int                INSN_W = 32,
    parameter logic [INSN_W-1:0] NOP    = NOP_INSN,
    parameter int                CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [INSN_W-1:0] imem_insn,
    input  logic              ld_stall,
    input  logic              md_busy,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic [INSN_W-1:0] fd_insn,
    output logic [INSN_W-1:0] dx_insn,
    output logic [INSN_W-1:0] xm_insn,
    output logic [INSN_W-1:0] mw_insn,
    output logic [ADDR_W-1:0] fd_pc,
    output logic [ADDR_W-1:0] dx_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // A branch cannot sit in X while multdiv owns it, so md_busy masks it.
    logic flush;
    logic stall_evt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    stage_op_e fd_op;
    stage_op_e dx_op;

    assign flush     = br_taken & ~md_busy;
    assign stall_evt = (ld_stall | md_busy) & ~flush;
    assign pc_inc    = pc_q + ADDR_W'(1);

    always_comb begin
        fd_op = STAGE_ADVANCE;
        dx_op = STAGE_ADVANCE;
        pc_d  = pc_inc;
        if (flush) begin
            fd_op = STAGE_BUBBLE;
            dx_op = STAGE_BUBBLE;
            pc_d  = br_target;
        end else if (md_busy) begin
            fd_op = STAGE_HOLD;
            dx_op = STAGE_HOLD;
            pc_d  = pc_q;
        end else if (ld_stall) begin
            fd_op = STAGE_HOLD;
            dx_op = STAGE_BUBBLE;
            pc_d  = pc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    pipe_reg #(.W(INSN_W), .CLR_VAL(NOP)) u_fd_insn (
        .clock(clock), .reset(reset),
        .en_i(fd_op == STAGE_ADVANCE), .clr_i(fd_op == STAGE_BUBBLE),
        .d_i(imem_insn), .q_o(fd_insn)
    );

    pipe_reg #(.W(ADDR_W), .CLR_VAL('0)) u_fd_pc (
        .clock(clock), .reset(reset),
        .en_i(fd_op == STAGE_ADVANCE), .clr_i(fd_op == STAGE_BUBBLE),
        .d_i(pc_inc), .q_o(fd_pc)
    );

    pipe_reg #(.W(INSN_W), .CLR_VAL(NOP)) u_dx_insn (
        .clock(clock), .reset(reset),
        .en_i(dx_op == STAGE_ADVANCE), .clr_i(dx_op == STAGE_BUBBLE),
        .d_i(fd_insn), .q_o(dx_insn)
    );

    pipe_reg #(.W(ADDR_W), .CLR_VAL('0)) u_dx_pc (
        .clock(clock), .reset(reset),
        .en_i(dx_op == STAGE_ADVANCE), .clr_i(dx_op == STAGE_BUBBLE),
        .d_i(fd_pc), .q_o(dx_pc)
    );

    // The branch in D/X always moves on; multdiv results bypass X/M entirely.
    pipe_reg #(.W(INSN_W), .CLR_VAL(NOP)) u_xm_insn (
        .clock(clock), .reset(reset),
        .en_i(1'b1), .clr_i(md_busy),
        .d_i(dx_insn), .q_o(xm_insn)
    );

    pipe_reg #(.W(INSN_W), .CLR_VAL(NOP)) u_mw_insn (
        .clock(clock), .reset(reset),
        .en_i(1'b1), .clr_i(1'b0),
        .d_i(xm_insn), .q_o(mw_insn)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clock(clock), .reset(reset), .inc_i(stall_evt), .cnt_o(stall_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clock(clock), .reset(reset), .inc_i(flush), .cnt_o(flush_cnt)
    );

endmodule

// File: tb/tb_pipe_insn_ctrl.sv
// Self-checking bench for pipe_insn_ctrl: directed scenarios plus a
// randomized run compared against a behavioural pipeline model.
module tb_pipe_insn_ctrl;

    localparam int ADDR_W = 12;
    localparam int INSN_W = 32;
    localparam int CNT_W  = 16;
    localparam logic [INSN_W-1:0] NOP = 32'h0000_0000;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [INSN_W-1:0] imem_insn;
    logic              ld_stall = 1'b0;
    logic              md_busy = 1'b0;
    logic              br_taken = 1'b0;
    logic [ADDR_W-1:0] br_target = '0;
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] fd_insn, dx_insn, xm_insn, mw_insn;
    logic [ADDR_W-1:0] fd_pc, dx_pc;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              imem_rand = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    pipe_insn_ctrl #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .NOP(NOP), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .imem_insn(imem_insn),
        .ld_stall(ld_stall), .md_busy(md_busy), .br_taken(br_taken), .br_target(br_target),
        .pc(pc), .fd_insn(fd_insn), .dx_insn(dx_insn), .xm_insn(xm_insn), .mw_insn(mw_insn),
        .fd_pc(fd_pc), .dx_pc(dx_pc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    // Instruction memory: a pure function of the fetch address.
    function automatic logic [INSN_W-1:0] rom(input logic [ADDR_W-1:0] a, input logic rnd);
        if (rnd) return {a, a ^ 12'h5A5, 8'hC3};
        return 32'h0800_0001 + {20'd0, a};
    endfunction

    assign imem_insn = imem_rand ? {pc, pc ^ 12'h5A5, 8'hC3} : 32'h0800_0001 + {20'd0, pc};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; ld_stall = 0; md_busy = 0; br_taken = 0; br_target = '0;
    endtask

    // Behavioural model: per-stage contents updated from the stage rules.
    int m_pc, m_fdpc, m_dxpc, m_sc, m_fc;
    logic [INSN_W-1:0] m_fd, m_dx, m_xm, m_mw;

    task automatic model_step();
        int n_pc, n_fdpc, n_dxpc, n_sc, n_fc;
        logic [INSN_W-1:0] n_fd, n_dx, n_xm, n_mw;
        bit fl;
        if (reset) begin
            m_pc = 0; m_fdpc = 0; m_dxpc = 0; m_sc = 0; m_fc = 0;
            m_fd = NOP; m_dx = NOP; m_xm = NOP; m_mw = NOP;
            return;
        end
        fl = br_taken && !md_busy;
        n_mw = m_xm;
        n_xm = md_busy ? NOP : m_dx;
        n_fd = m_fd; n_fdpc = m_fdpc; n_dx = m_dx; n_dxpc = m_dxpc; n_pc = m_pc;
        if (fl) begin
            n_pc = br_target; n_fd = NOP; n_fdpc = 0; n_dx = NOP; n_dxpc = 0;
        end else if (!md_busy) begin
            if (ld_stall) begin
                n_dx = NOP; n_dxpc = 0;
            end else begin
                n_dx = m_fd; n_dxpc = m_fdpc;
                n_fd = rom(m_pc[ADDR_W-1:0], imem_rand);
                n_fdpc = (m_pc + 1) % (1 << ADDR_W);
                n_pc = (m_pc + 1) % (1 << ADDR_W);
            end
        end
        n_sc = m_sc; n_fc = m_fc;
        if ((ld_stall || md_busy) && !fl && m_sc < (1 << CNT_W) - 1) n_sc = m_sc + 1;
        if (fl && m_fc < (1 << CNT_W) - 1) n_fc = m_fc + 1;
        m_pc = n_pc; m_fdpc = n_fdpc; m_dxpc = n_dxpc; m_sc = n_sc; m_fc = n_fc;
        m_fd = n_fd; m_dx = n_dx; m_xm = n_xm; m_mw = n_mw;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; br_taken = 1; br_target = 12'h3AB; ld_stall = 1;
        tick();
        clear_inputs();
        n_checks++; if (pc !== 0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc); end
        n_checks++; if ({fd_insn, dx_insn, xm_insn, mw_insn} !== {4{NOP}}) begin n_fail++; $display("FAIL reset_insn: got %h %h %h %h want all nop", fd_insn, dx_insn, xm_insn, mw_insn); end
        n_checks++; if ({fd_pc, dx_pc} !== '0) begin n_fail++; $display("FAIL reset_stage_pc: got %h %h want 0", fd_pc, dx_pc); end
        n_checks++; if ({stall_cnt, flush_cnt} !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h %h want 0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++; if (pc !== ADDR_W'(i)) begin n_fail++; $display("FAIL free_pc[%0d]: got %h want %h", i, pc, i); end
        end
        n_checks++; if (mw_insn !== rom(2, 0)) begin n_fail++; $display("FAIL free_mw: got %h want %h", mw_insn, rom(2, 0)); end
        n_checks++; if (xm_insn !== rom(3, 0) || dx_insn !== rom(4, 0) || fd_insn !== rom(5, 0)) begin n_fail++; $display("FAIL free_stages: got %h %h %h", xm_insn, dx_insn, fd_insn); end
        n_checks++; if (fd_pc !== 12'd6 || dx_pc !== 12'd5) begin n_fail++; $display("FAIL free_stage_pc: got %h %h want 6 5", fd_pc, dx_pc); end
        n_checks++; if ({stall_cnt, flush_cnt} !== '0) begin n_fail++; $display("FAIL free_cnt: got %h %h want 0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_ld_stall();
        ld_stall = 1;
        tick();
        ld_stall = 0;
        n_checks++; if (pc !== 12'd6) begin n_fail++; $display("FAIL stall_pc: got %h want 6", pc); end
        n_checks++; if (fd_insn !== rom(5, 0)) begin n_fail++; $display("FAIL stall_fd: got %h want %h", fd_insn, rom(5, 0)); end
        n_checks++; if (dx_insn !== NOP || dx_pc !== 0) begin n_fail++; $display("FAIL stall_bubble: got %h/%h want nop/0", dx_insn, dx_pc); end
        n_checks++; if (xm_insn !== rom(4, 0)) begin n_fail++; $display("FAIL stall_xm: got %h want %h", xm_insn, rom(4, 0)); end
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_cnt: got %h want 1", stall_cnt); end
        tick();
        n_checks++; if (dx_insn !== rom(5, 0) || dx_pc !== 12'd6) begin n_fail++; $display("FAIL stall_release_dx: got %h/%h want %h/6", dx_insn, dx_pc, rom(5, 0)); end
        n_checks++; if (xm_insn !== NOP || pc !== 12'd7) begin n_fail++; $display("FAIL stall_release: got xm %h pc %h want nop 7", xm_insn, pc); end
    endtask

    task automatic test_flush();
        br_taken = 1; br_target = 12'h100;
        tick();
        br_taken = 0;
        n_checks++; if (pc !== 12'h100) begin n_fail++; $display("FAIL flush_pc: got %h want 100", pc); end
        n_checks++; if (fd_insn !== NOP || dx_insn !== NOP || fd_pc !== 0 || dx_pc !== 0) begin n_fail++; $display("FAIL flush_squash: got %h %h %h %h", fd_insn, dx_insn, fd_pc, dx_pc); end
        n_checks++; if (xm_insn !== rom(5, 0)) begin n_fail++; $display("FAIL flush_branch: got %h want %h", xm_insn, rom(5, 0)); end
        n_checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_cnt: got %h %h want 1 1", flush_cnt, stall_cnt); end
    endtask

    task automatic test_md_busy();
        repeat (3) tick();
        md_busy = 1; br_taken = 1; br_target = 12'h055;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (pc !== 12'h103 || fd_insn !== rom(12'h102, 0) || dx_insn !== rom(12'h101, 0)) begin n_fail++; $display("FAIL md_hold[%0d]: got %h %h %h", i, pc, fd_insn, dx_insn); end
            n_checks++; if (xm_insn !== NOP) begin n_fail++; $display("FAIL md_xm[%0d]: got %h want nop", i, xm_insn); end
            n_checks++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL md_br_ignored[%0d]: got %h want 1", i, flush_cnt); end
        end
        n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL md_stall_cnt: got %h want 4", stall_cnt); end
        md_busy = 0; br_taken = 0;
        tick();
        n_checks++; if (xm_insn !== rom(12'h101, 0) || pc !== 12'h104) begin n_fail++; $display("FAIL md_release: got %h %h", xm_insn, pc); end
    endtask

    task automatic test_pc_wrap();
        br_taken = 1; br_target = 12'hFFF;
        tick();
        br_taken = 0;
        tick();
        n_checks++; if (pc !== 12'h000) begin n_fail++; $display("FAIL wrap_pc: got %h want 000", pc); end
        n_checks++; if (fd_insn !== rom(12'hFFF, 0) || fd_pc !== 12'h000) begin n_fail++; $display("FAIL wrap_fd: got %h/%h want %h/000", fd_insn, fd_pc, rom(12'hFFF, 0)); end
    endtask

    task automatic test_stall_saturate();
        reset = 1;
        tick();
        clear_inputs();
        ld_stall = 1;
        repeat (65535) tick();
        n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", stall_cnt); end
        repeat (4) tick();
        n_checks++; if (stall_cnt !== 16'hFFFF || pc !== 0) begin n_fail++; $display("FAIL sat_hold: got %h pc %h want ffff 0", stall_cnt, pc); end
        ld_stall = 0;
    endtask

    task automatic test_reset_during_flush();
        repeat (3) tick();
        br_taken = 1; br_target = 12'h200; reset = 1;
        tick();
        clear_inputs();
        n_checks++; if (pc !== 0 || {fd_insn, dx_insn, xm_insn, mw_insn} !== {4{NOP}}) begin n_fail++; $display("FAIL rst_flush_state: got pc %h insns %h %h %h %h", pc, fd_insn, dx_insn, xm_insn, mw_insn); end
        n_checks++; if ({fd_pc, dx_pc, stall_cnt, flush_cnt} !== '0) begin n_fail++; $display("FAIL rst_flush_regs: got %h %h %h %h", fd_pc, dx_pc, stall_cnt, flush_cnt); end
        tick();
        n_checks++; if (pc !== 12'd1 || fd_insn !== rom(0, 0)) begin n_fail++; $display("FAIL rst_restart: got %h %h", pc, fd_insn); end
    endtask

    task automatic test_random();
        logic [INSN_W-1:0] act [11];
        logic [INSN_W-1:0] exp [11];
        imem_rand = 1;
        reset = 1;
        model_step();
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset     = ($urandom_range(0, 39) == 0);
            br_taken  = ($urandom_range(0, 5) == 0);
            md_busy   = ($urandom_range(0, 5) == 0);
            ld_stall  = ($urandom_range(0, 4) == 0);
            br_target = ADDR_W'($urandom);
            model_step();
            tick();
            act = '{INSN_W'(pc), fd_insn, dx_insn, xm_insn, mw_insn, INSN_W'(fd_pc), INSN_W'(dx_pc),
                    INSN_W'(stall_cnt), INSN_W'(flush_cnt), 32'd0, 32'd0};
            exp = '{INSN_W'(m_pc), m_fd, m_dx, m_xm, m_mw, INSN_W'(m_fdpc), INSN_W'(m_dxpc),
                    INSN_W'(m_sc), INSN_W'(m_fc), 32'd0, 32'd0};
            for (int k = 0; k < 9; k++) begin
                n_checks++;
                if (act[k] !== exp[k]) begin
                    n_fail++;
                    $display("FAIL random[%0d] out%0d: got %h want %h", cyc, k, act[k], exp[k]);
                end
            end
        end
        clear_inputs();
        imem_rand = 0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ld_stall();
        test_flush();
        test_md_busy();
        test_pc_wrap();
        test_reset_during_flush();
        test_stall_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
